// File: rtl/pwm_pkg.sv
// Shared widths and constants for the PWM output stage.
// Also holds the single-bit PWM compare used by the top level.
package pwm_pkg;

    localparam int PWM_CNT_W       = 8;
    localparam int OUT_W           = 16;
    localparam int DEFAULT_CLK_DIV = 13;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX   = 8'hFF;

    // A full-scale duty forces the level high so there is no one-tick dip at cnt == 255.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler producing a tick every CLK_DIV clocks,
// plus an 8-bit free-running period counter and its wrap detect.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] cnt,
    output logic                 tick,
    output logic                 wrap
);

    localparam logic [PWM_CNT_W-1:0] PRE_LAST = PWM_CNT_W'(CLK_DIV - 1);

    logic [PWM_CNT_W-1:0] pre;

    assign tick = (pre == PRE_LAST);
    assign wrap = tick && (cnt == CNT_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= cnt + PWM_CNT_W'(1);
        end else begin
            pre <= pre + PWM_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output stage: per-bit static low / static high / shared PWM selection,
// with the duty cycle shadowed at the period wrap so mid-period writes cannot glitch.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       en_reg_out_7_0,
    input  logic [7:0]       en_reg_out_15_8,
    input  logic [7:0]       en_reg_pwm_7_0,
    input  logic [7:0]       en_reg_pwm_15_8,
    input  logic [7:0]       pwm_duty_cycle,
    output logic [OUT_W-1:0] out,
    output logic             period_start
);

    logic [PWM_CNT_W-1:0] cnt;
    logic [PWM_CNT_W-1:0] duty_sh;
    logic                 tick;
    logic                 wrap;
    logic                 pwm_raw;
    logic [OUT_W-1:0]     en_out;
    logic [OUT_W-1:0]     en_pwm;
    logic [OUT_W-1:0]     out_next;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .tick  (tick),
        .wrap  (wrap)
    );

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign pwm_raw  = pwm_level(cnt, duty_sh);
    assign out_next = en_out & (~en_pwm | {OUT_W{pwm_raw}});

    // Enables act on the next edge; only the duty is deferred to the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh      <= '0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            if (tick && (cnt == CNT_MAX)) begin
                duty_sh <= pwm_duty_cycle;
            end
            out          <= out_next;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (CLK_DIV=2 main instance, CLK_DIV=1 side instance).
// Expected results are queued when stimulus is applied and popped when the output is measured.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
    logic [15:0] out, out1;
    logic        period_start, period_start1;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (period_start1)
    );

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Window measurement of out[0] on the CLK_DIV=2 instance.
    int   m_n, m_high, m_edges, m_ps, m_ps_at;
    logic m_prev;

    function automatic void expect_push(input string name, input logic [31:0] value);
        exp_q.push_back('{name, value});
    endfunction

    task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_out_lo = eo[7:0];
        en_out_hi = eo[15:8];
        en_pwm_lo = ep[7:0];
        en_pwm_hi = ep[15:8];
        duty      = d;
    endtask

    task automatic wait_wrap(input bit div1, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(div1 ? period_start1 : period_start) && n < budget);
        if (!(div1 ? period_start1 : period_start)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_wrap: no period_start within %0d clk", budget);
        end
    endtask

    task automatic clear_meas();
        m_n = 0; m_high = 0; m_edges = 0; m_ps = 0; m_ps_at = 0;
        m_prev = out[0];
    endtask

    task automatic run_meas(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            m_n++;
            if (out[0] === 1'b1) m_high++;
            if (out[0] !== m_prev) m_edges++;
            m_prev = out[0];
            if (period_start) begin
                m_ps++;
                if (m_ps_at == 0) m_ps_at = m_n;
            end
        end
    endtask

    task automatic hold_count(input int n, input logic [15:0] value, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out !== value) bad++;
        end
    endtask

    task automatic test_reset();
        int n, bad;
        set_inputs(16'hFFFF, 16'hFFFF, 8'hFF);
        rst_n = 1'b0;
        expect_push("reset_out", 32'h0);
        expect_push("reset_period_start", 32'h0);
        repeat (3) @(posedge clk);
        #1;
        e = exp_q.pop_front(); n_tests++;
        if ({16'h0, out} !== e.value) begin
            n_fail++; $display("FAIL %s: out=0x%0h expected 0x%0h", e.name, out, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if ({31'h0, period_start} !== e.value) begin
            n_fail++; $display("FAIL %s: period_start=%0b expected %0d", e.name, period_start, e.value);
        end

        expect_push("first_period_len", 32'd512);
        expect_push("first_period_nonzero_out", 32'd0);
        expect_push("after_wrap_not_ffff", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; bad = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (out !== 16'h0000) bad++;
        end while (!period_start && n < 600);
        e = exp_q.pop_front(); n_tests++;
        if (n !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d clk expected %0d", e.name, n, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (bad !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d cycles expected %0d", e.name, bad, e.value);
        end
        hold_count(512, 16'hFFFF, bad);
        e = exp_q.pop_front(); n_tests++;
        if (bad !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d cycles expected %0d", e.name, bad, e.value);
        end
    endtask

    task automatic test_static_modes();
        int n, bad;
        set_inputs(16'h00F0, 16'h0000, 8'hFF);
        expect_push("static_one_clk", 32'h00F0);
        expect_push("static_hold_bad", 32'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_tests++;
        if ({16'h0, out} !== e.value) begin
            n_fail++; $display("FAIL %s: out=0x%0h expected 0x%0h", e.name, out, e.value);
        end
        hold_count(20, 16'h00F0, bad);
        e = exp_q.pop_front(); n_tests++;
        if (bad !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d cycles expected %0d", e.name, bad, e.value);
        end

        // Old shadow duty is still 0xFF, so PWM bits stay high until the wrap.
        set_inputs(16'h00F0, 16'h0030, 8'h00);
        expect_push("pwm_sel_before_wrap", 32'h00F0);
        expect_push("pwm_duty0_after_wrap", 32'h00C0);
        expect_push("pwm_duty0_hold_bad", 32'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_tests++;
        if ({16'h0, out} !== e.value) begin
            n_fail++; $display("FAIL %s: out=0x%0h expected 0x%0h", e.name, out, e.value);
        end
        wait_wrap(1'b0, 600, n);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_tests++;
        if ({16'h0, out} !== e.value) begin
            n_fail++; $display("FAIL %s: out=0x%0h expected 0x%0h", e.name, out, e.value);
        end
        hold_count(20, 16'h00C0, bad);
        e = exp_q.pop_front(); n_tests++;
        if (bad !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d cycles expected %0d", e.name, bad, e.value);
        end
    endtask

    task automatic test_duty_50();
        int n;
        set_inputs(16'h0001, 16'h0001, 8'h80);
        wait_wrap(1'b0, 600, n);
        expect_push("d50_high_clk", 32'd256);
        expect_push("d50_edges", 32'd2);
        expect_push("d50_ps_count", 32'd1);
        expect_push("d50_ps_at", 32'd512);
        clear_meas();
        run_meas(512);
        e = exp_q.pop_front(); n_tests++;
        if (m_high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_high, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_edges !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_edges, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_ps !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_ps, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_ps_at !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_ps_at, e.value);
        end
    endtask

    task automatic test_mid_period_change();
        int n;
        duty = 8'h40;
        wait_wrap(1'b0, 600, n);
        expect_push("mid_cur_high_clk", 32'd128);
        expect_push("mid_cur_edges", 32'd2);
        expect_push("mid_next_high_clk", 32'd384);
        expect_push("mid_next_edges", 32'd2);
        clear_meas();
        run_meas(200);
        duty = 8'hC0;
        run_meas(312);
        e = exp_q.pop_front(); n_tests++;
        if (m_high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_high, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_edges !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_edges, e.value);
        end
        clear_meas();
        run_meas(512);
        e = exp_q.pop_front(); n_tests++;
        if (m_high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_high, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_edges !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_edges, e.value);
        end
    endtask

    task automatic test_extremes();
        int n;
        duty = 8'h01;
        wait_wrap(1'b0, 600, n);
        expect_push("d01_high_clk", 32'd2);
        expect_push("d01_edges", 32'd2);
        clear_meas();
        run_meas(512);
        e = exp_q.pop_front(); n_tests++;
        if (m_high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_high, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_edges !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_edges, e.value);
        end

        duty = 8'hFF;
        wait_wrap(1'b0, 600, n);
        expect_push("dff_high_clk_3_periods", 32'd1536);
        expect_push("dff_ps_count", 32'd3);
        clear_meas();
        run_meas(1536);
        e = exp_q.pop_front(); n_tests++;
        if (m_high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_high, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (m_ps !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_ps, e.value);
        end

        // Duty changes just before and just after the wrap edge: only the first is captured.
        expect_push("wrap_edge_ps", 32'd1);
        expect_push("wrap_edge_capture_high_clk", 32'd32);
        clear_meas();
        run_meas(511);
        duty = 8'h10;
        clear_meas();
        run_meas(1);
        duty = 8'h20;
        e = exp_q.pop_front(); n_tests++;
        if (m_ps !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_ps, e.value);
        end
        clear_meas();
        run_meas(512);
        e = exp_q.pop_front(); n_tests++;
        if (m_high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, m_high, e.value);
        end
    endtask

    task automatic test_async_reset();
        int n;
        set_inputs(16'hFFFF, 16'h0000, 8'h80);
        expect_push("pre_reset_out", 32'hFFFF);
        expect_push("async_reset_out", 32'h0);
        expect_push("async_reset_ps", 32'h0);
        expect_push("restart_period_len", 32'd512);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_tests++;
        if ({16'h0, out} !== e.value) begin
            n_fail++; $display("FAIL %s: out=0x%0h expected 0x%0h", e.name, out, e.value);
        end
        #2 rst_n = 1'b0;
        #1;
        e = exp_q.pop_front(); n_tests++;
        if ({16'h0, out} !== e.value) begin
            n_fail++; $display("FAIL %s: out=0x%0h expected 0x%0h", e.name, out, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if ({31'h0, period_start} !== e.value) begin
            n_fail++; $display("FAIL %s: period_start=%0b expected %0d", e.name, period_start, e.value);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_wrap(1'b0, 600, n);
        e = exp_q.pop_front(); n_tests++;
        if (n !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d clk expected %0d", e.name, n, e.value);
        end
    endtask

    task automatic test_clk_div1();
        int n, high, ps;
        set_inputs(16'h0001, 16'h0001, 8'h80);
        expect_push("div1_period_len", 32'd256);
        expect_push("div1_high_clk", 32'd128);
        expect_push("div1_ps_count", 32'd1);
        wait_wrap(1'b1, 300, n);
        wait_wrap(1'b1, 300, n);
        e = exp_q.pop_front(); n_tests++;
        if (n !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d clk expected %0d", e.name, n, e.value);
        end
        high = 0; ps = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (out1[0] === 1'b1) high++;
            if (period_start1) ps++;
        end
        e = exp_q.pop_front(); n_tests++;
        if (high !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, high, e.value);
        end
        e = exp_q.pop_front(); n_tests++;
        if (ps !== int'(e.value)) begin
            n_fail++; $display("FAIL %s: %0d expected %0d", e.name, ps, e.value);
        end
    endtask

    initial begin
        test_reset();
        test_static_modes();
        test_duty_50();
        test_mid_period_change();
        test_extremes();
        test_async_reset();
        test_clk_div1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
